// File: rtl/connect4_pkg.sv
// ============================================================================
// Module   : connect4_pkg
// Brief    : Shared board dimensions and move-conditioner state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package connect4_pkg;

   localparam int NUM_COLUMNS = 4;
   localparam int COL_W       = 4;

   typedef enum logic [1:0] {
      LOCKOUT      = 2'd0,
      IDLE         = 2'd1,
      WAIT_RELEASE = 2'd2
   } mic_state_e;

endpackage

`default_nettype wire

// File: rtl/debounce_sync.sv
// ============================================================================
// Module   : debounce_sync
// Brief    : Two-flop synchroniser followed by a stability-count debouncer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_sync #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Any cycle where the input agrees with the level restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = level_q;

endmodule

`default_nettype wire

// File: rtl/move_input_conditioner.sv
// ============================================================================
// Module   : move_input_conditioner
// Brief    : Turns a bouncing push-button plus column switches into one
//            accept/reject strobe per press with a latched column index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_input_conditioner
   import connect4_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int NUM_COLUMNS     = connect4_pkg::NUM_COLUMNS,
   parameter int COL_W           = connect4_pkg::COL_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   btn_raw,
   input  logic [COL_W-1:0]       switches,
   input  logic [NUM_COLUMNS-1:0] col_full,
   input  logic                   game_active,
   output logic                   move_valid,
   output logic                   move_reject,
   output logic [COL_W-1:0]       move_column,
   output logic                   busy
);

   // The synchroniser resets to 0, so a button held through reset only shows
   // up on the debounced level ~DEBOUNCE_CYCLES+2 cycles later. Lockout
   // therefore needs the level to stay low for longer than that.
   localparam int LOCK_CYCLES = DEBOUNCE_CYCLES + 4;
   localparam int LOCK_W      = $clog2(LOCK_CYCLES);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

   logic                   btn_deb;
   logic [COL_W-1:0]       sw_meta_q;
   logic [COL_W-1:0]       sw_sync_q;
   logic                   btn_prev_q;
   logic                   press_q;
   logic                   press_d;
   mic_state_e             state_q;
   mic_state_e             state_d;
   logic [LOCK_W-1:0]      lock_cnt_q;
   logic [LOCK_W-1:0]      lock_cnt_d;
   logic                   move_valid_q;
   logic                   move_valid_d;
   logic                   move_reject_q;
   logic                   move_reject_d;
   logic [COL_W-1:0]       move_column_q;
   logic [COL_W-1:0]       move_column_d;
   logic                   busy_q;
   logic                   busy_d;
   logic                   accept;

   debounce_sync #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clk   (clk),
      .reset (reset),
      .din   (btn_raw),
      .dout  (btn_deb)
   );

   // Matching against each legal index keeps col_full from ever being
   // indexed with an out-of-range column.
   always_comb begin
      accept = 1'b0;
      for (int i = 0; i < NUM_COLUMNS; i++) begin
         if ((sw_sync_q == COL_W'(i)) && !col_full[i]) begin
            accept = 1'b1;
         end
      end
      accept = accept & game_active;
   end

   always_comb begin
      press_d       = btn_deb & ~btn_prev_q;
      state_d       = state_q;
      lock_cnt_d    = '0;
      move_valid_d  = 1'b0;
      move_reject_d = 1'b0;
      move_column_d = move_column_q;
      busy_d        = busy_q;
      case (state_q)
         LOCKOUT: begin
            busy_d = 1'b0;
            if (!btn_deb) begin
               if (lock_cnt_q == LOCK_LAST) begin
                  state_d = IDLE;
               end else begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end
         end
         IDLE: begin
            if (press_q) begin
               move_column_d = sw_sync_q;
               move_valid_d  = accept;
               move_reject_d = ~accept;
               busy_d        = 1'b1;
               state_d       = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (!btn_deb) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = LOCKOUT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_meta_q     <= '0;
         sw_sync_q     <= '0;
         btn_prev_q    <= 1'b0;
         press_q       <= 1'b0;
         state_q       <= LOCKOUT;
         lock_cnt_q    <= '0;
         move_valid_q  <= 1'b0;
         move_reject_q <= 1'b0;
         move_column_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         sw_meta_q     <= switches;
         sw_sync_q     <= sw_meta_q;
         btn_prev_q    <= btn_deb;
         press_q       <= press_d;
         state_q       <= state_d;
         lock_cnt_q    <= lock_cnt_d;
         move_valid_q  <= move_valid_d;
         move_reject_q <= move_reject_d;
         move_column_q <= move_column_d;
         busy_q        <= busy_d;
      end
   end

   assign move_valid  = move_valid_q;
   assign move_reject = move_reject_q;
   assign move_column = move_column_q;
   assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_move_input_conditioner.sv
// ============================================================================
// Module   : tb_move_input_conditioner
// Brief    : Scoreboard bench for move_input_conditioner with a press-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_move_input_conditioner;

   localparam int DC = 16;
   localparam int NC = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          btn_raw = 1'b0;
   logic [CW-1:0] switches = '0;
   logic [NC-1:0] col_full = '0;
   logic          game_active = 1'b0;
   logic          move_valid;
   logic          move_reject;
   logic [CW-1:0] move_column;
   logic          busy;

   typedef struct {
      bit            valid;
      logic [CW-1:0] col;
      int unsigned   cyc;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   move_input_conditioner #(
      .DEBOUNCE_CYCLES (DC),
      .NUM_COLUMNS     (NC),
      .COL_W           (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .switches    (switches),
      .col_full    (col_full),
      .game_active (game_active),
      .move_valid  (move_valid),
      .move_reject (move_reject),
      .move_column (move_column),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // A press is accepted only in a running game, on an in-range, non-full column.
   function automatic bit model_accept(input int sw, input logic [NC-1:0] cf, input bit ga);
      if (!ga) return 1'b0;
      if (sw >= NC) return 1'b0;
      return ((cf >> sw) & 1) == 0;
   endfunction

   // Stable press driven now is first sampled next edge; strobe visible DC+4 negedges later.
   task automatic expect_press(input int sw, input logic [NC-1:0] cf, input bit ga);
      exp_t e;
      e.valid = model_accept(sw, cf, ga);
      e.col   = CW'(sw);
      e.cyc   = cyc + DC + 4;
      exp_q.push_back(e);
   endtask

   task automatic press(input int sw, input logic [NC-1:0] cf, input bit ga,
                        input int bounces, input int hold, input bit disturb);
      switches    = CW'(sw);
      col_full    = cf;
      game_active = ga;
      tick(4);
      for (int b = 0; b < bounces; b++) begin
         btn_raw = 1'b1;
         tick(3);
         btn_raw = 1'b0;
         tick(3);
      end
      btn_raw = 1'b1;
      expect_press(sw, cf, ga);
      tick(DC + 6);
      if (disturb) begin
         switches    = CW'($urandom_range(0, 15));
         col_full    = NC'($urandom_range(0, 15));
         game_active = 1'($urandom_range(0, 1));
      end
      tick(hold);
      chk("busy_while_held", {31'd0, busy}, 32'd1);
      chk("column_held", {28'd0, move_column}, 32'(sw));
      btn_raw = 1'b0;
      tick(2);
      btn_raw = 1'b1;
      tick(2);
      btn_raw = 1'b0;
      tick(DC + 8);
      chk("busy_after_release", {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_outputs_clear(input string tag);
      chk({tag, "_valid"}, {31'd0, move_valid}, 32'd0);
      chk({tag, "_reject"}, {31'd0, move_reject}, 32'd0);
      chk({tag, "_column"}, {28'd0, move_column}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   // Monitor: every strobe must match the oldest outstanding expected press.
   initial begin
      forever begin
         @(negedge clk);
         if (move_valid || move_reject) begin
            chk("single_strobe_kind", {31'd0, move_valid & move_reject}, 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_strobe: valid=%0b reject=%0b col=%0d, required no strobe (cycle %0d)",
                        move_valid, move_reject, move_column, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("strobe_accept", {31'd0, move_valid}, {31'd0, mon_e.valid});
               chk("strobe_column", {28'd0, move_column}, {28'd0, mon_e.col});
               chk("strobe_cycle", cyc, mon_e.cyc);
            end
         end
      end
   end

   initial begin
      int unsigned r;

      // Reset state
      reset = 1'b1;
      tick(2);
      chk_outputs_clear("reset");
      reset = 1'b0;
      tick(DC + 8);

      // 1: clean press, exact latency and release timing
      switches    = 4'd2;
      col_full    = '0;
      game_active = 1'b1;
      tick(4);
      btn_raw = 1'b1;
      expect_press(2, '0, 1'b1);
      tick(40);
      chk("t1_busy_held", {31'd0, busy}, 32'd1);
      chk("t1_column", {28'd0, move_column}, 32'd2);
      btn_raw = 1'b0;
      r = cyc;
      tick(DC + 2);
      chk("t1_busy_before_release_edge", {31'd0, busy}, 32'd1);
      chk("t1_release_cycle", cyc, r + DC + 2);
      tick(1);
      chk("t1_busy_cleared", {31'd0, busy}, 32'd0);
      tick(10);

      // 2: bouncing press
      press(3, '0, 1'b1, 5, 4, 1'b0);

      // 3: out-of-range, full column, then accepted column
      press(5, '0, 1'b1, 0, 2, 1'b0);
      press(1, 4'b0010, 1'b1, 0, 2, 1'b0);
      press(1, 4'b0000, 1'b1, 0, 2, 1'b0);

      // 4: no game in progress
      press(0, '0, 1'b0, 0, 2, 1'b0);

      // 5: button held across reset must not count
      switches = 4'd1;
      btn_raw  = 1'b1;
      tick(5);
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(40);
      btn_raw = 1'b0;
      tick(46);
      press(1, '0, 1'b1, 0, 3, 1'b0);

      // 6: switch change while busy, then reset during release wait
      switches    = 4'd3;
      col_full    = '0;
      game_active = 1'b1;
      tick(4);
      btn_raw = 1'b1;
      expect_press(3, '0, 1'b1);
      tick(DC + 6);
      switches = 4'd0;
      tick(5);
      chk("t6_column_kept", {28'd0, move_column}, 32'd3);
      chk("t6_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      tick(1);
      chk_outputs_clear("t6_reset");
      tick(1);
      reset = 1'b0;
      tick(40);
      btn_raw = 1'b0;
      tick(46);
      press(2, '0, 1'b1, 0, 3, 1'b0);

      // Randomised presses with bounces and post-strobe disturbances
      for (int n = 0; n < 12; n++) begin
         press(int'($urandom_range(0, 7)), NC'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 15)), 1'b1);
      end

      tick(10);
      chk("pending_strobes", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/move_input_conditioner.md
Name: move_input_conditioner

Overview:
- Front-end stage between the raw board inputs (BTN_EAST push-button, Switch_3..Switch_0) and the column calculator / column counter path.
- Synchronises and debounces the button, then emits exactly one single-cycle move request per physical press, carrying the latched column.
- Rejects a move if the column index is out of range, the column is already full, or no game is in progress.
- Downstream logic consumes a clean strobe instead of a raw, bouncing level.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required before the debounced level changes. Use 16 for simulation; the board build overrides it to 500000.
- NUM_COLUMNS, 4: number of playable columns. Valid index range is 0..NUM_COLUMNS-1.
- COL_W, 4: width of the switch bus and of the column index.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- btn_raw  in  1  asynchronous push-button (BTN_EAST).
- switches  in  COL_W  asynchronous column switches {Switch_3,Switch_2,Switch_1,Switch_0}, binary column index.
- col_full  in  NUM_COLUMNS  bit i high = column i has no free cell (from column counters).
- game_active  in  1  high while the FSM is in a playing state.
- move_valid  out  1  one-cycle strobe: accepted move.
- move_reject  out  1  one-cycle strobe: press was ignored.
- move_column  out  COL_W  column latched at the last press; held between presses.
- busy  out  1  high from press detection until the debounced release.

Behaviour:
- Clocking and reset: everything is clocked on the rising edge of clk. Reset is synchronous, active-high, and has priority over all other logic.
- Reset values: move_valid=0, move_reject=0, move_column=0, busy=0, synchroniser flops=0, debounced level=0, debounce counter=0, state=LOCKOUT.
- Synchronisers: btn_raw and every switches bit pass through 2-flop synchronisers. Only synchronised values are used.
- Debounce counter:
  - Counter clears whenever the synchronised button equals the debounced level.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- FSM states:
  - LOCKOUT: entered at reset. Waits for debounced=0, then goes to IDLE. A button held through reset is therefore never counted as a press.
  - IDLE: on a debounced rising edge, on the same edge:
    - capture the synchronised switches into move_column;
    - evaluate acceptance;
    - register exactly one of move_valid or move_reject high for one cycle;
    - set busy=1 and go to WAIT_RELEASE.
  - WAIT_RELEASE: ignores all inputs until debounced=0, then busy=0 and state goes to IDLE. Bounces during release are absorbed by the debouncer.
- Accept condition: game_active=1 AND move_column < NUM_COLUMNS AND col_full[move_column]=0.
  - Out-of-range index: treat as reject. col_full is never indexed out of range.
  - Inputs are sampled in the same cycle as the capture.
- Latency: btn_raw first sampled high at edge k and held stable gives move_valid/move_reject high for exactly the cycle after edge k+DEBOUNCE_CYCLES+3.
- Pulse rules:
  - Exactly one strobe per press, never both.
  - Strobe width is exactly 1 cycle, even if the button is held indefinitely.
- Switch changes while busy do not alter move_column.
- Changes to col_full or game_active after the strobe have no effect on it.
- Reset mid-press:
  - all outputs clear on the next edge;
  - state returns to LOCKOUT;
  - a release is then required before any new strobe.

Decomposition:
- Shared package (connect4_pkg): NUM_COLUMNS, COL_W, and the FSM state encoding (LOCKOUT=2'd0, IDLE=2'd1, WAIT_RELEASE=2'd2).
- Sub-module debounce_sync: 2-flop synchroniser plus debounce counter for one bit. Parameter DEBOUNCE_CYCLES; ports clk, reset, din, dout.
  - Instantiate it once for the button.
  - The switches use plain 2-flop synchronisers only.

Test Plan:
1. Reset, then btn_raw=1 held for 40 cycles with switches=2, col_full=0, game_active=1 → one move_valid pulse exactly DEBOUNCE_CYCLES+3 (=19) edges after the first high sample; move_column=2; busy stays high until 19 cycles after release.
2. btn_raw bursts of 1/0 at 3-cycle intervals for 30 cycles, then stable 1 → no strobe during the bursts; exactly one move_valid after the stable period.
3. switches=5 (NUM_COLUMNS=4) → move_reject pulse, move_column=5. Then switches=1 with col_full=4'b0010 → move_reject. Then switches=1 with col_full=0 → move_valid.
4. game_active=0, switches=0, press → move_reject; no move_valid.
5. btn_raw held high across reset deassertion → no strobe; release (≥19 cycles), press again → one move_valid.
6. Press accepted, change switches 3→0 while busy, assert reset during WAIT_RELEASE → move_column stays 3 until reset; after reset all outputs are 0 and the state is LOCKOUT.
